// File: rtl/lif_pkg.sv
// Shared defaults, control-op encoding and arithmetic helpers for the LIF layer datapath.
package lif_pkg;

  localparam int N_IN_DEF    = 16;
  localparam int N_OUT_DEF   = 8;
  localparam int W_W_DEF     = 8;
  localparam int W_V_DEF     = 16;
  localparam int THRESH_DEF  = 100;
  localparam int LEAK_SH_DEF = 3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLR,
    OP_INIT,
    OP_STEP,
    OP_WR1,
    OP_WR0,
    OP_NEXT
  } lif_op_e;

  function automatic int addr_w(input int n_in, input int n_out);
    return (n_in * n_out > 1) ? $clog2(n_in * n_out) : 1;
  endfunction

  // Clamp a wide signed sum into the range of a w-bit signed value (w <= 32).
  function automatic logic signed [32:0] sat_clamp(input logic signed [32:0] s, input int w);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/lif_sat_add.sv
// Combinational saturating add of a sign-extended weight onto the membrane accumulator.
module lif_sat_add
  import lif_pkg::*;
#(
  parameter int W_V = W_V_DEF,
  parameter int W_W = W_W_DEF
) (
  input  logic signed [W_V-1:0] acc_i,
  input  logic signed [W_W-1:0] w_i,
  output logic signed [W_V-1:0] sum_o
);

  logic signed [W_V:0] sum_wide;

  // One guard bit is enough: |w| is always smaller than the accumulator range.
  assign sum_wide = {acc_i[W_V-1], acc_i} + {{(W_V + 1 - W_W){w_i[W_W-1]}}, w_i};
  assign sum_o    = W_V'(sat_clamp(33'(sum_wide), W_V));

endmodule

// File: rtl/lif_dp.sv
// LIF layer datapath: neuron counters, leaky membrane accumulator, persistent membranes
// and the output spike vector, driven by one-cycle pulses from the layer controller.
module lif_dp
  import lif_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int W_W     = W_W_DEF,
  parameter int W_V     = W_V_DEF,
  parameter int THRESH  = THRESH_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr_all,
  input  logic                                 acc_init,
  input  logic                                 acc_step,
  input  logic                                 wr1,
  input  logic                                 wr0,
  input  logic                                 next_out,
  input  logic                                 v_clr,
  input  logic [N_IN-1:0]                      in_spk,
  output logic [addr_w(N_IN, N_OUT)-1:0]       w_addr,
  input  logic signed [W_W-1:0]                w_data,
  output logic                                 ini_last,
  output logic                                 out_last,
  output logic                                 fired,
  output logic [N_OUT-1:0]                     spk_out,
  output logic                                 spk_vld
);

  localparam int AW = addr_w(N_IN, N_OUT);
  localparam int IW = $clog2(N_IN);
  localparam int OW = $clog2(N_OUT);
  localparam logic signed [W_V-1:0] THR_V = W_V'(THRESH);

  logic [IW-1:0]         in_idx_q,  in_idx_d;
  logic [OW-1:0]         out_idx_q, out_idx_d;
  logic signed [W_V-1:0] acc_q,     acc_d;
  logic signed [W_V-1:0] v_mem_q [N_OUT];
  logic signed [W_V-1:0] v_mem_d [N_OUT];
  logic [N_OUT-1:0]      spk_out_q, spk_out_d;
  logic                  spk_vld_q, spk_vld_d;

  lif_op_e               op;
  logic signed [W_V-1:0] v_cur;
  logic signed [W_V-1:0] v_leak;
  logic signed [W_V-1:0] acc_sum;

  assign w_addr   = AW'(out_idx_q) * AW'(N_IN) + AW'(in_idx_q);
  assign ini_last = (in_idx_q == IW'(N_IN - 1));
  assign out_last = (out_idx_q == OW'(N_OUT - 1));
  assign fired    = (acc_q >= THR_V);
  assign spk_out  = spk_out_q;
  assign spk_vld  = spk_vld_q;

  // Subtracting a down-shifted copy of v moves it toward zero, so the leak never overflows.
  assign v_cur  = v_mem_q[out_idx_q];
  assign v_leak = v_cur - (v_cur >>> LEAK_SH);

  lif_sat_add #(
    .W_V (W_V),
    .W_W (W_W)
  ) u_sat_add (
    .acc_i (acc_q),
    .w_i   (w_data),
    .sum_o (acc_sum)
  );

  // Pulses are expected one-hot; the chain below resolves any overlap by fixed priority.
  always_comb begin
    op = OP_NONE;
    if (clr_all)       op = OP_CLR;
    else if (acc_init) op = OP_INIT;
    else if (acc_step) op = OP_STEP;
    else if (wr1)      op = OP_WR1;
    else if (wr0)      op = OP_WR0;
    else if (next_out) op = OP_NEXT;
  end

  always_comb begin
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    acc_d     = acc_q;
    spk_out_d = spk_out_q;
    spk_vld_d = spk_vld_q;
    v_mem_d   = v_mem_q;

    unique case (op)
      OP_CLR: begin
        in_idx_d  = '0;
        out_idx_d = '0;
        spk_out_d = '0;
        spk_vld_d = 1'b0;
      end
      OP_INIT: begin
        acc_d    = v_leak;
        in_idx_d = '0;
      end
      OP_STEP: begin
        if (in_spk[in_idx_q]) acc_d = acc_sum;
        if (!ini_last) in_idx_d = in_idx_q + IW'(1);
      end
      OP_WR1: begin
        spk_out_d[out_idx_q] = 1'b1;
        v_mem_d[out_idx_q]   = '0;
      end
      OP_WR0: begin
        spk_out_d[out_idx_q] = 1'b0;
        v_mem_d[out_idx_q]   = acc_q;
      end
      OP_NEXT: begin
        if (out_last) begin
          out_idx_d = '0;
          spk_vld_d = 1'b1;
        end else begin
          out_idx_d = out_idx_q + OW'(1);
        end
      end
      default: ;
    endcase

    if (v_clr) begin
      for (int i = 0; i < N_OUT; i++) v_mem_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_idx_q  <= '0;
      out_idx_q <= '0;
      acc_q     <= '0;
      spk_out_q <= '0;
      spk_vld_q <= 1'b0;
      for (int i = 0; i < N_OUT; i++) v_mem_q[i] <= '0;
    end else begin
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      acc_q     <= acc_d;
      spk_out_q <= spk_out_d;
      spk_vld_q <= spk_vld_d;
      for (int i = 0; i < N_OUT; i++) v_mem_q[i] <= v_mem_d[i];
    end
  end

endmodule

// File: tb/tb_lif_dp.sv
// Directed bench for lif_dp: a default-width instance plus a W_V=10 instance for saturation.
module tb_lif_dp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_all = 1'b0, acc_init = 1'b0, acc_step = 1'b0;
  logic        wr1 = 1'b0, wr0 = 1'b0, next_out = 1'b0, v_clr = 1'b0;
  logic [15:0] in_spk = '0;

  logic [6:0]         w_addr, s_w_addr;
  logic signed [7:0]  w_data, s_w_data;
  logic               ini_last, out_last, fired;
  logic               s_ini_last, s_out_last, s_fired;
  logic [7:0]         spk_out, s_spk_out;
  logic               spk_vld, s_spk_vld;

  logic signed [7:0] wrom [128];
  logic signed [7:0] srom [128];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign w_data   = wrom[w_addr];
  assign s_w_data = srom[s_w_addr];

  lif_dp u_dut (
    .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .acc_init(acc_init), .acc_step(acc_step),
    .wr1(wr1), .wr0(wr0), .next_out(next_out), .v_clr(v_clr), .in_spk(in_spk),
    .w_addr(w_addr), .w_data(w_data), .ini_last(ini_last), .out_last(out_last),
    .fired(fired), .spk_out(spk_out), .spk_vld(spk_vld)
  );

  lif_dp #(.W_V(10)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .acc_init(acc_init), .acc_step(acc_step),
    .wr1(wr1), .wr0(wr0), .next_out(next_out), .v_clr(v_clr), .in_spk(in_spk),
    .w_addr(s_w_addr), .w_data(s_w_data), .ini_last(s_ini_last), .out_last(s_out_last),
    .fired(s_fired), .spk_out(s_spk_out), .spk_vld(s_spk_vld)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 clr_all, 1 acc_init, 2 acc_step, 3 wr1, 4 wr0, 5 next_out, 6 v_clr
  task automatic pulse(input int op);
    case (op)
      0: clr_all  = 1'b1;
      1: acc_init = 1'b1;
      2: acc_step = 1'b1;
      3: wr1      = 1'b1;
      4: wr0      = 1'b1;
      5: next_out = 1'b1;
      default: v_clr = 1'b1;
    endcase
    tick();
    {clr_all, acc_init, acc_step, wr1, wr0, next_out, v_clr} = '0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) pulse(2);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      wrom[i] = 8'sd10;
      srom[i] = 8'sd0;
    end
    repeat (2) tick();

    // Reset state
    check_eq("rst_ini_last", ini_last, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_fired", fired, 0);
    check_eq("rst_spk_out", spk_out, 0);
    check_eq("rst_spk_vld", spk_vld, 0);
    check_eq("rst_w_addr", w_addr, 0);
    check_eq("rst_acc", u_dut.acc_q, 0);
    check_eq("rst_s_spk", {s_spk_vld, s_spk_out}, 0);
    rst_n = 1'b1;
    tick();

    // 1: all spikes, weights 10 -> 160, fires
    in_spk = 16'hFFFF;
    pulse(6);
    pulse(0);
    pulse(1);
    check_eq("t1_acc_init", u_dut.acc_q, 0);
    steps(16);
    check_eq("t1_acc", u_dut.acc_q, 160);
    check_eq("t1_ini_last", ini_last, 1);
    check_eq("t1_fired", fired, 1);
    pulse(3);
    check_eq("t1_spk_out", spk_out, 8'h01);
    check_eq("t1_vmem0", u_dut.v_mem_q[0], 0);

    // 2: single spike on input 0, two timesteps with leak
    in_spk = 16'h0001;
    wrom[0] = 8'sd5;
    pulse(0);
    pulse(1);
    steps(16);
    check_eq("t2_acc_ts1", u_dut.acc_q, 5);
    check_eq("t2_fired_ts1", fired, 0);
    pulse(4);
    check_eq("t2_vmem_ts1", u_dut.v_mem_q[0], 5);
    check_eq("t2_spk_ts1", spk_out, 0);
    pulse(0);
    pulse(1);
    check_eq("t2_leak", u_dut.acc_q, 5);
    steps(16);
    check_eq("t2_acc_ts2", u_dut.acc_q, 10);
    check_eq("t2_fired_ts2", fired, 0);
    pulse(4);
    check_eq("t2_vmem_ts2", u_dut.v_mem_q[0], 10);

    // 3: W_V=10 saturation both directions
    in_spk = 16'hFFFF;
    for (int i = 0; i < 128; i++) srom[i] = 8'sd127;
    pulse(6);
    pulse(0);
    pulse(1);
    steps(4);
    check_eq("t3_pos_4", u_sat.acc_q, 508);
    steps(1);
    check_eq("t3_pos_5", u_sat.acc_q, 511);
    steps(11);
    check_eq("t3_pos_16", u_sat.acc_q, 511);
    check_eq("t3_s_ini_last", s_ini_last, 1);
    check_eq("t3_s_fired", s_fired, 1);
    for (int i = 0; i < 128; i++) srom[i] = -8'sd128;
    pulse(6);
    pulse(1);
    check_eq("t3_neg_init", u_sat.acc_q, 0);
    steps(4);
    check_eq("t3_neg_4", u_sat.acc_q, -512);
    steps(12);
    check_eq("t3_neg_16", u_sat.acc_q, -512);
    check_eq("t3_s_fired_neg", s_fired, 0);
    check_eq("t3_s_out_last", s_out_last, 0);

    // 4: 20 steps on neuron 2, index saturates at 15
    for (int i = 0; i < 128; i++) wrom[i] = 8'sd10;
    pulse(0);
    pulse(5);
    pulse(5);
    pulse(1);
    check_eq("t4_addr_init", w_addr, 32);
    check_eq("t4_ini_init", ini_last, 0);
    for (int k = 1; k <= 20; k++) begin
      pulse(2);
      check_eq($sformatf("t4_addr_%0d", k), w_addr, 32 + ((k < 15) ? k : 15));
      check_eq($sformatf("t4_ini_%0d", k), ini_last, (k >= 15) ? 1 : 0);
    end

    // 5: full pass of 8 neurons, even ones fire
    pulse(0);
    for (int n = 0; n < 8; n++) begin
      check_eq($sformatf("t5_out_last_%0d", n), out_last, (n == 7) ? 1 : 0);
      check_eq($sformatf("t5_addr_%0d", n), w_addr, n * 16);
      pulse((n % 2 == 0) ? 3 : 4);
      if (n == 7) check_eq("t5_vld_pre", spk_vld, 0);
      pulse(5);
    end
    check_eq("t5_wrap_addr", w_addr, 0);
    check_eq("t5_wrap_out_last", out_last, 0);
    check_eq("t5_spk_vld", spk_vld, 1);
    check_eq("t5_spk_out", spk_out, 8'h55);
    pulse(0);
    check_eq("t5_clr_spk_out", spk_out, 0);
    check_eq("t5_clr_spk_vld", spk_vld, 0);

    // 6: asynchronous reset in the middle of a step on neuron 3
    pulse(3);
    pulse(5);
    pulse(5);
    pulse(5);
    pulse(1);
    steps(5);
    check_eq("t6_pre_addr", w_addr, 53);
    acc_step = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_acc", u_dut.acc_q, 0);
    check_eq("t6_w_addr", w_addr, 0);
    check_eq("t6_ini_last", ini_last, 0);
    check_eq("t6_out_last", out_last, 0);
    check_eq("t6_fired", fired, 0);
    check_eq("t6_spk_out", spk_out, 0);
    check_eq("t6_spk_vld", spk_vld, 0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("t6_vmem_%0d", i), u_dut.v_mem_q[i], 0);
    acc_step = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Restart at neuron 0 with a sparse pattern and ramp weights: 4+5+6+7 = 22
    for (int i = 0; i < 128; i++) wrom[i] = 8'(i);
    in_spk = 16'h00F0;
    pulse(0);
    pulse(1);
    check_eq("t6_restart_addr", w_addr, 0);
    check_eq("t6_restart_acc", u_dut.acc_q, 0);
    steps(16);
    check_eq("t6_restart_sum", u_dut.acc_q, 22);
    check_eq("t6_restart_fired", fired, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_dp.md
Name: lif_dp

Overview:
- Datapath responder for the LIF layer controller. Consumes the controller's one-cycle control pulses (clr_all, acc_init, acc_step, wr1, wr0, next_out) and returns the status flags it branches on (ini_last, out_last, fired).
- Holds the input/output neuron counters, the membrane accumulator, per-neuron persistent membrane storage and the output spike vector.
- Fetches synaptic weights from an external combinational weight ROM.

Parameters:
- N_IN, 16, input neurons per layer (≥2)
- N_OUT, 8, output neurons per layer (≥2)
- W_W, 8, signed weight width
- W_V, 16, signed membrane/accumulator width (> W_W)
- THRESH, 100, signed firing threshold (W_V bits)
- LEAK_SH, 3, leak shift: v_leaked = v − (v >>> LEAK_SH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- clr_all  in  1  layer start: clear counters and spike vector
- acc_init  in  1  load accumulator with leaked membrane of current output neuron
- acc_step  in  1  accumulate one input synapse
- wr1  in  1  commit "fired" for current output neuron
- wr0  in  1  commit "not fired" for current output neuron
- next_out  in  1  advance output neuron counter
- v_clr  in  1  zero all stored membranes
- in_spk  in  N_IN  input spike vector, stable for the whole layer pass
- w_addr  out  clog2(N_IN*N_OUT)  weight address = out_idx*N_IN + in_idx, combinational
- w_data  in  W_W  signed weight at w_addr, valid in the same cycle
- ini_last  out  1  in_idx == N_IN−1, combinational
- out_last  out  1  out_idx == N_OUT−1, combinational
- fired  out  1  acc ≥ THRESH (signed), combinational
- spk_out  out  N_OUT  registered output spikes
- spk_vld  out  1  spk_out holds a complete layer result

Behaviour:
- Clock and reset: rst_n is asynchronous, active-low; clk is the clock. Reset zeroes in_idx, out_idx, acc, all v_mem entries, spk_out and spk_vld.
- Status outputs after reset: ini_last = 0, out_last = 0, fired = 0 (THRESH > 0).
- Contract: control pulses are one-hot. If violated, priority is clr_all > acc_init > acc_step > wr1 > wr0 > next_out. v_clr is independent and overrides any v_mem write in the same cycle.
- clr_all: in_idx←0, out_idx←0, spk_out←0, spk_vld←0. Membranes are untouched; they persist across timesteps.
- acc_init: acc←v_mem[out_idx] − (v_mem[out_idx] >>> LEAK_SH) (arithmetic shift); in_idx←0.
- acc_step:
  - If in_spk[in_idx]=1: acc←sat(acc + sext(w_data)); otherwise acc holds.
  - in_idx←in_idx+1 if in_idx < N_IN−1; otherwise it holds at N_IN−1 (no wrap).
- Controller handshake: the controller samples ini_last during the acc_step cycle. The step with in_idx = N_IN−1 is therefore the last accumulate. fired is valid in the following cycle, using the registered acc.
- wr1: spk_out[out_idx]←1; v_mem[out_idx]←0 (reset-to-zero).
- wr0: spk_out[out_idx]←0; v_mem[out_idx]←acc.
- next_out:
  - If out_last: out_idx←0 and spk_vld←1.
  - Otherwise: out_idx←out_idx+1.
- Saturation: sum computed at W_V+1 bits, then clamped to [−2^(W_V−1), 2^(W_V−1)−1]. The leak step cannot overflow.
- Latency per output neuron: acc_init, N_IN × acc_step, decide, write, next_out = N_IN+4 cycles.
- Reset mid-pass returns all state to reset values. Stored membranes are lost by design.
- The weight ROM is combinational. w_addr changes only on counter updates.

Decomposition:
- Package lif_pkg: default widths, THRESH, LEAK_SH, the address-width function, and a saturating-add function.
- One sub-module, lif_sat_add: signed W_V + sign-extended W_W with clamp, purely combinational.
- Membrane storage is an N_OUT × W_V register array inside lif_dp.

Test Plan:
1. Reset, v_clr, all in_spk=1, all weights=10, one neuron pass → acc=160, fired=1, wr1 gives spk_out[0]=1 and v_mem[0]=0.
2. in_spk=16'h0001, w[0]=5, two timesteps on neuron 0 → acc=5 then 5−(5>>>3)+5=10; fired=0 both times; v_mem[0]=10.
3. W_V=10, all spikes, weights=127 → acc clamps at 511. Weights=−128 → clamps at −512, no wrap.
4. 20 consecutive acc_step pulses → ini_last high only once in_idx=15; in_idx holds at 15; w_addr = out_idx*16+15.
5. Full pass of 8 neurons with next_out → out_last at out_idx=7, then out_idx=0 and spk_vld=1. A following clr_all clears spk_out and spk_vld.
6. rst_n asserted mid-acc_step on neuron 3 → all counters, acc, v_mem, spk_out and status outputs are zero asynchronously. The next pass restarts at neuron 0.
